// File: rtl/mips32_mem_arbiter_if.sv
// Bundle of pipeline-side request/response signals and RAM-side bus for the
// unified memory arbiter. slave = arbiter side, master = pipeline + RAM side.
interface mips32_mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          halted;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall;

    // Handshake: a requester holds req and its address/data stable until the
    // cycle gnt=1; that cycle is the transfer. Reads return rvalid/rdata
    // exactly one cycle after gnt. Dropping req before gnt withdraws it.
    modport slave (
        input  halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, stall
    );

    modport master (
        output halted, if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, stall
    );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// IF/DM arbiter for a single-port synchronous RAM: DM priority with an IF
// starvation guard. Optional grant statistics under MIPS32_ARB_STATS_EN.
module mips32_mem_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                   clk1,
    input  logic                   rst,
    mips32_mem_arbiter_if.slave    bus,
    output logic [1:0]             fsm_state
`ifdef MIPS32_ARB_STATS_EN
    ,
    output logic [15:0]            stat_if_cnt,
    output logic [15:0]            stat_dm_cnt,
    output logic [15:0]            stat_conflict_cnt
`endif
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_DM = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] starve_cnt;
    logic          if_ok;
    logic          force_if;
    logic          if_gnt;
    logic          dm_gnt;

    assign fsm_state = state_q;

    always_comb begin
        if_ok    = bus.if_req & ~bus.halted;
        force_if = if_ok & (starve_cnt == SW'(STARVE_MAX));
        if_gnt   = ~rst & if_ok & (force_if | ~bus.dm_req);
        dm_gnt   = ~rst & bus.dm_req & ~force_if;
        state_d  = IDLE;
        if (if_gnt)
            state_d = RESP_IF;
        else if (dm_gnt & ~bus.dm_we)
            state_d = RESP_DM;
    end

    always_comb begin
        bus.if_gnt    = if_gnt;
        bus.dm_gnt    = dm_gnt;
        bus.mem_en    = if_gnt | dm_gnt;
        bus.mem_we    = dm_gnt & bus.dm_we;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (if_gnt)
            bus.mem_addr = bus.if_addr;
        else if (dm_gnt)
            bus.mem_addr = bus.dm_addr;
        if (dm_gnt & bus.dm_we)
            bus.mem_wdata = bus.dm_wdata;
        bus.stall = ~rst & ((if_ok & ~if_gnt) | (bus.dm_req & ~dm_gnt));
        // Responses are gated by rst so a read in flight at reset never surfaces.
        bus.if_rvalid = ~rst & (state_q == RESP_IF);
        bus.dm_rvalid = ~rst & (state_q == RESP_DM);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.dm_rdata  = bus.dm_rvalid ? bus.mem_rdata : '0;
    end

    always_ff @(posedge clk1) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk1) begin
        if (rst || if_gnt || !bus.if_req || bus.halted)
            starve_cnt <= '0;
        else if (dm_gnt && starve_cnt != SW'(STARVE_MAX))
            starve_cnt <= starve_cnt + 1'b1;
    end

`ifdef MIPS32_ARB_STATS_EN
    logic conflict;
    assign conflict = if_ok & bus.dm_req;

    always_ff @(posedge clk1) begin
        if (rst) begin
            stat_if_cnt       <= '0;
            stat_dm_cnt       <= '0;
            stat_conflict_cnt <= '0;
        end else begin
            if (if_gnt && stat_if_cnt != 16'hFFFF)
                stat_if_cnt <= stat_if_cnt + 16'd1;
            if (dm_gnt && stat_dm_cnt != 16'hFFFF)
                stat_dm_cnt <= stat_dm_cnt + 16'd1;
            if (conflict && stat_conflict_cnt != 16'hFFFF)
                stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Directed bench for mips32_mem_arbiter with a write-first RAM model and a
// response scoreboard; build with MIPS32_ARB_STATS_EN to cover the counters.
module tb_mips32_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic [1:0] fsm_state;
  int n_tests = 0;
  int n_fail  = 0;

  mips32_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef MIPS32_ARB_STATS_EN
  logic [15:0] stat_if_cnt, stat_dm_cnt, stat_conflict_cnt;
  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk1(clk1), .rst(rst), .bus(bus), .fsm_state(fsm_state),
    .stat_if_cnt(stat_if_cnt), .stat_dm_cnt(stat_dm_cnt),
    .stat_conflict_cnt(stat_conflict_cnt)
  );
`else
  mips32_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
    .clk1(clk1), .rst(rst), .bus(bus), .fsm_state(fsm_state)
  );
`endif

  // clock / reset
  always #5 clk1 = ~clk1;

  function automatic logic [DW-1:0] init_word(logic [AW-1:0] a);
    return 32'h2801000a + 32'(a) * 32'h00010003;
  endfunction

  // RAM model: 1-cycle read latency, write-first
  logic [DW-1:0] ram [1024];
  bit            ram_written [1024];
  always @(posedge clk1) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        ram[bus.mem_addr]         <= bus.mem_wdata;
        ram_written[bus.mem_addr] <= 1'b1;
        bus.mem_rdata             <= bus.mem_wdata;
      end else begin
        bus.mem_rdata <= ram_written[bus.mem_addr] ? ram[bus.mem_addr] : init_word(bus.mem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: reference memory and expected-response queues
  logic [DW-1:0] ref_mem [1024];
  bit            ref_written [1024];
  logic [DW-1:0] exp_if_q[$];
  logic [DW-1:0] exp_dm_q[$];
  bit if_pend = 0;
  bit dm_pend = 0;

  always @(negedge clk1) begin
    logic [DW-1:0] e;
    if (rst) begin
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
      chk("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
      if_pend = 0;
      dm_pend = 0;
      exp_if_q.delete();
      exp_dm_q.delete();
    end else begin
      chk("if_rvalid", 32'(bus.if_rvalid), 32'(if_pend));
      chk("dm_rvalid", 32'(bus.dm_rvalid), 32'(dm_pend));
      if (if_pend) begin
        e = exp_if_q.pop_front();
        if (bus.if_rvalid) chk("if_rdata", bus.if_rdata, e);
      end
      if (dm_pend) begin
        e = exp_dm_q.pop_front();
        if (bus.dm_rvalid) chk("dm_rdata", bus.dm_rdata, e);
      end
      if_pend = 0;
      dm_pend = 0;
      if (bus.if_gnt) begin
        exp_if_q.push_back(ref_written[bus.if_addr] ? ref_mem[bus.if_addr] : init_word(bus.if_addr));
        if_pend = 1;
      end
      if (bus.dm_gnt) begin
        if (bus.dm_we) begin
          ref_mem[bus.dm_addr]     = bus.dm_wdata;
          ref_written[bus.dm_addr] = 1'b1;
        end else begin
          exp_dm_q.push_back(ref_written[bus.dm_addr] ? ref_mem[bus.dm_addr] : init_word(bus.dm_addr));
          dm_pend = 1;
        end
      end
    end
  end

  // driver: apply inputs just after posedge, then wait for the sampling edge
  task automatic drive(input logic r, input logic h, input logic ir, input logic [AW-1:0] ia,
                       input logic dr, input logic dw, input logic [AW-1:0] da,
                       input logic [DW-1:0] dd);
    @(posedge clk1);
    #1;
    rst = r; bus.halted = h;
    bus.if_req = ir; bus.if_addr = ia;
    bus.dm_req = dr; bus.dm_we = dw; bus.dm_addr = da; bus.dm_wdata = dd;
    @(negedge clk1);
  endtask

  task automatic chk_gnt(input string tag, input logic eif, input logic edm, input logic est);
    chk({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'(eif));
    chk({tag, "_dm_gnt"}, 32'(bus.dm_gnt), 32'(edm));
    chk({tag, "_stall"},  32'(bus.stall),  32'(est));
  endtask

  initial begin
    bus.halted = 0; bus.if_req = 0; bus.if_addr = '0;
    bus.dm_req = 0; bus.dm_we = 0; bus.dm_addr = '0; bus.dm_wdata = '0;

    // 1. reset with both requests pending
    drive(1, 0, 1, 10'd5, 1, 0, 10'd5, 32'd0);
    drive(1, 0, 1, 10'd5, 1, 0, 10'd5, 32'd0);
    chk_gnt("rst", 0, 0, 0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    chk("rst_fsm", 32'(fsm_state), 32'd0);
    drive(0, 0, 1, 10'd5, 1, 0, 10'd5, 32'd0);
    chk_gnt("rel", 0, 1, 1);
    chk("rel_mem_addr", 32'(bus.mem_addr), 32'd5);
    drive(0, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);

    // 2. IF-only stream, one fetch per cycle
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, AW'(i), 0, 0, 10'd0, 32'd0);
      chk_gnt("ifonly", 1, 0, 0);
      chk("ifonly_mem_addr", 32'(bus.mem_addr), 32'(i));
      chk("ifonly_mem_we", 32'(bus.mem_we), 32'd0);
    end
    drive(0, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);

    // 3. sustained conflict: IF forced through after four DM wins
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 10'd3, 1, 0, 10'd7, 32'd0);
      chk_gnt("conflict", (i == 4), (i != 4), 1);
    end
    drive(0, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);

    // 4. store then load same address
    drive(0, 0, 0, 10'd0, 1, 1, 10'd20, 32'h0000002d);
    chk_gnt("store", 0, 1, 0);
    chk("store_mem_we", 32'(bus.mem_we), 32'd1);
    chk("store_mem_wdata", bus.mem_wdata, 32'h0000002d);
    drive(0, 0, 0, 10'd0, 1, 0, 10'd20, 32'h0);
    chk_gnt("load", 0, 1, 0);
    chk("load_mem_we", 32'(bus.mem_we), 32'd0);
    chk("load_mem_wdata", bus.mem_wdata, 32'd0);
    drive(0, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);
    chk("st_ld_data_const", ref_mem[20], 32'h0000002d);

    // 5. halted pipeline: IF masked, DM still served
    drive(0, 1, 1, 10'd3, 0, 0, 10'd0, 32'd0);
    chk_gnt("halt", 0, 0, 0);
    chk("halt_mem_en", 32'(bus.mem_en), 32'd0);
    chk("halt_starve", 32'(dut.starve_cnt), 32'd0);
    drive(0, 1, 1, 10'd3, 1, 0, 10'd9, 32'd0);
    chk_gnt("halt_dm", 0, 1, 0);
    drive(0, 1, 1, 10'd3, 0, 0, 10'd0, 32'd0);
    chk("halt_starve2", 32'(dut.starve_cnt), 32'd0);
    drive(0, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);

    // 6. reset right after an IF grant discards the response
    drive(0, 0, 1, 10'd2, 0, 0, 10'd0, 32'd0);
    chk_gnt("pre_rst", 1, 0, 0);
    drive(1, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);
    chk("rst_mid_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    drive(0, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);
    chk("post_rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
    chk("post_rst_fsm", 32'(fsm_state), 32'd0);
`ifdef MIPS32_ARB_STATS_EN
    chk("stat_if", 32'(stat_if_cnt), 32'd0);
    chk("stat_dm", 32'(stat_dm_cnt), 32'd0);
    chk("stat_conflict", 32'(stat_conflict_cnt), 32'd0);
`endif
    drive(0, 0, 0, 10'd0, 0, 0, 10'd0, 32'd0);
    chk("if_q_empty", 32'(exp_if_q.size()), 32'd0);
    chk("dm_q_empty", 32'(exp_dm_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
